// File: rtl/div_arbiter.sv
// div_arbiter
//   Two-requester round-robin front end for one shared sequential divider.
//   Only one operation is in flight at a time. The flow is:
//     IDLE  -> pick a winner and latch its operands
//     ISSUE -> pulse div_start for one cycle
//     WAIT  -> wait for div_done, or give up after TIMEOUT cycles
//     RESP  -> pulse the winner's ack for one cycle
//   A zero divisor skips the divider: the block goes from IDLE straight to
//   RESP and returns q=FFFF, r=a, err=1.
//
// Parameters
//   TIMEOUT   : WAIT cycles without div_done before aborting (2..255)
//
// Ports
//   clk, rst         : rising-edge clock, synchronous active-high reset
//   req0/req1        : requester k has an operation pending
//   a0/a1, b0/b1     : dividend / divisor of requester k (stable while reqk)
//   ack0/ack1        : one-cycle response-valid pulse for requester k
//   q_out/r_out      : quotient / remainder of the most recent response
//   err_out          : most recent response was divide-by-zero or timeout
//   busy             : high in every state except IDLE
//   grant_id         : requester currently being served
//   div_start        : one-cycle start pulse to the divider
//   div_a/div_b      : registered operands to the divider
//   div_done         : divider completion (pulse or level)
//   div_q/div_r      : divider results, valid while div_done=1
module div_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] a0,
  input  logic [15:0] a1,
  input  logic [15:0] b0,
  input  logic [15:0] b1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] q_out,
  output logic [15:0] r_out,
  output logic        err_out,
  output logic        busy,
  output logic        grant_id,
  output logic        div_start,
  output logic [15:0] div_a,
  output logic [15:0] div_b,
  input  logic        div_done,
  input  logic [15:0] div_q,
  input  logic [15:0] div_r
);

  localparam int DATA_W = 16;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [7:0]          cnt;
  logic                last;
  logic                any_req;
  logic                win;
  logic [DATA_W-1:0]   win_a;
  logic [DATA_W-1:0]   win_b;
  logic                win_zero;
  logic                to_hit;

  // Tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    any_req  = req0 | req1;
    win      = (req0 && req1) ? ~last : req1;
    win_a    = win ? a1 : a0;
    win_b    = win ? b1 : b0;
    win_zero = (win_b == '0);
    to_hit   = (cnt == TO_LAST);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = win_zero ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (div_done || to_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs decode directly from the registered state.
  assign busy      = (state != IDLE);
  assign div_start = (state == ISSUE);
  assign ack0      = (state == RESP) && !grant_id;
  assign ack1      = (state == RESP) &&  grant_id;

  // Operand latch, wait counter, response registers and round-robin pointer.
  // last resets to 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      last     <= 1'b1;
      grant_id <= 1'b0;
      div_a    <= '0;
      div_b    <= '0;
      q_out    <= '0;
      r_out    <= '0;
      err_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= win;
            div_a    <= win_a;
            div_b    <= win_b;
            if (win_zero) begin
              q_out   <= '1;
              r_out   <= win_a;
              err_out <= 1'b1;
            end
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (div_done) begin
            q_out   <= div_q;
            r_out   <= div_r;
            err_out <= 1'b0;
          end else if (to_hit) begin
            q_out   <= '0;
            r_out   <= '0;
            err_out <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP:    last <= grant_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter
//   Directed bench for div_arbiter. The main instance uses the default
//   TIMEOUT and has its divider handshake driven step by step; a second
//   instance with TIMEOUT=8 has div_done held low to exercise the abort.
module tb_div_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [15:0] a0, a1, b0, b1;
  logic        div_done;
  logic [15:0] div_q, div_r;

  logic        ack0, ack1, err_out, busy, grant_id, div_start;
  logic [15:0] q_out, r_out, div_a, div_b;

  logic        t_req0, t_req1, t_done;
  logic [15:0] t_dq, t_dr;
  logic        t_ack0, t_ack1, t_err, t_busy, t_grant, t_start;
  logic [15:0] t_q, t_r, t_da, t_db;

  int passed;
  int total;

  div_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .ack0(ack0), .ack1(ack1),
    .q_out(q_out), .r_out(r_out), .err_out(err_out),
    .busy(busy), .grant_id(grant_id), .div_start(div_start),
    .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  div_arbiter #(.TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst),
    .req0(t_req0), .req1(t_req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .ack0(t_ack0), .ack1(t_ack1),
    .q_out(t_q), .r_out(t_r), .err_out(t_err),
    .busy(t_busy), .grant_id(t_grant), .div_start(t_start),
    .div_a(t_da), .div_b(t_db),
    .div_done(t_done), .div_q(t_dq), .div_r(t_dr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    div_done = 1'b0; div_q = '0; div_r = '0;
    t_req0 = 1'b0; t_req1 = 1'b0; t_done = 1'b0; t_dq = '0; t_dr = '0;

    // ---------------- reset state
    step(2);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ack0", ack0, 1'b0);
    chk1("rst_ack1", ack1, 1'b0);
    chk1("rst_start", div_start, 1'b0);
    chk1("rst_grant", grant_id, 1'b0);
    chk1("rst_err", err_out, 1'b0);
    chk16("rst_q", q_out, 16'h0000);
    chk16("rst_r", r_out, 16'h0000);
    chk16("rst_div_a", div_a, 16'h0000);
    chk1("rst_to_busy", t_busy, 1'b0);
    rst = 1'b0;
    step(1);

    // ---------------- 100 / 7 with D=17
    a0 = 16'd100; b0 = 16'd7; req0 = 1'b1;
    step(1);                                   // sample edge -> ISSUE
    chk1("a_start", div_start, 1'b1);
    chk1("a_busy", busy, 1'b1);
    chk1("a_grant", grant_id, 1'b0);
    chk16("a_div_a", div_a, 16'd100);
    chk16("a_div_b", div_b, 16'd7);
    step(1);                                   // WAIT cycle 1
    chk1("a_start_pulse", div_start, 1'b0);
    step(15);                                  // WAIT cycle 16
    chk1("a_no_early_ack", ack0, 1'b0);
    chk16("a_div_a_stable", div_a, 16'd100);
    step(1);                                   // WAIT cycle 17
    div_done = 1'b1; div_q = 16'd14; div_r = 16'd2;
    step(1);                                   // RESP
    chk1("a_ack0", ack0, 1'b1);
    chk1("a_ack1", ack1, 1'b0);
    chk16("a_q", q_out, 16'd14);
    chk16("a_r", r_out, 16'd2);
    chk1("a_err", err_out, 1'b0);
    chk16("a_div_b_resp", div_b, 16'd7);
    req0 = 1'b0; div_done = 1'b0; div_q = 16'h5555; div_r = 16'h5555;
    step(1);                                   // IDLE
    chk1("a_ack_pulse", ack0, 1'b0);
    chk1("a_idle", busy, 1'b0);
    chk16("a_q_hold", q_out, 16'd14);

    // ---------------- tie after reset, then re-raised tie
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    a0 = 16'd50; b0 = 16'd5; a1 = 16'd9; b1 = 16'd4;
    req0 = 1'b1; req1 = 1'b1;
    step(1);                                   // ISSUE for req0
    chk1("b_grant0", grant_id, 1'b0);
    chk16("b_div_a0", div_a, 16'd50);
    div_done = 1'b1; div_q = 16'h0063; div_r = 16'h0063;   // must be ignored in ISSUE
    step(1);                                   // WAIT 1
    chk1("b_done_in_issue_ignored", busy, 1'b1);
    chk1("b_no_ack_w1", ack0, 1'b0);
    div_done = 1'b0;
    step(1);                                   // WAIT 2
    div_done = 1'b1; div_q = 16'd10; div_r = 16'd0;
    step(1);                                   // RESP
    chk1("b_ack0", ack0, 1'b1);
    chk16("b_q0", q_out, 16'd10);
    chk16("b_r0", r_out, 16'd0);
    req0 = 1'b0; div_done = 1'b0;
    step(1);                                   // IDLE
    chk1("b_idle0", busy, 1'b0);
    step(1);                                   // ISSUE for req1
    chk1("b_grant1", grant_id, 1'b1);
    chk16("b_div_a1", div_a, 16'd9);
    step(1);                                   // WAIT 1
    div_done = 1'b1; div_q = 16'd2; div_r = 16'd1;
    step(1);                                   // RESP
    chk1("b_ack1", ack1, 1'b1);
    chk1("b_ack0_low", ack0, 1'b0);
    chk16("b_q1", q_out, 16'd2);
    chk16("b_r1", r_out, 16'd1);
    req1 = 1'b0; div_done = 1'b0;
    step(1);                                   // IDLE
    req0 = 1'b1; req1 = 1'b1;
    step(1);                                   // ISSUE: req1 was last, req0 wins
    chk1("b_rr_grant0", grant_id, 1'b0);
    step(1);
    div_done = 1'b1; div_q = 16'd10; div_r = 16'd0;
    step(1);                                   // RESP
    chk1("b_rr_ack0", ack0, 1'b1);
    req0 = 1'b0; div_done = 1'b0;
    step(2);                                   // IDLE, then ISSUE for req1
    chk1("b_rr_grant1", grant_id, 1'b1);
    step(1);
    div_done = 1'b1; div_q = 16'd2; div_r = 16'd1;
    step(1);
    chk1("b_rr_ack1", ack1, 1'b1);
    req1 = 1'b0; div_done = 1'b0;
    step(1);

    // ---------------- divide by zero on requester 1
    a1 = 16'd1234; b1 = 16'd0; req1 = 1'b1;
    step(1);                                   // straight to RESP
    chk1("z_ack1", ack1, 1'b1);
    chk1("z_no_start", div_start, 1'b0);
    chk16("z_q", q_out, 16'hFFFF);
    chk16("z_r", r_out, 16'd1234);
    chk1("z_err", err_out, 1'b1);
    req1 = 1'b0;
    step(1);
    chk1("z_idle", busy, 1'b0);
    chk1("z_err_hold", err_out, 1'b1);
    chk1("z_no_start_after", div_start, 1'b0);

    // ---------------- timeout on the TIMEOUT=8 instance
    a0 = 16'd20; b0 = 16'd3; t_req0 = 1'b1;
    step(1);                                   // ISSUE
    chk1("t_start", t_start, 1'b1);
    step(8);                                   // WAIT cycle 8
    chk1("t_no_ack_w8", t_ack0, 1'b0);
    chk1("t_busy_w8", t_busy, 1'b1);
    step(1);                                   // RESP
    chk1("t_ack0", t_ack0, 1'b1);
    chk16("t_q", t_q, 16'd0);
    chk16("t_r", t_r, 16'd0);
    chk1("t_err", t_err, 1'b1);
    t_req0 = 1'b0;
    step(1);
    chk1("t_busy_fall", t_busy, 1'b0);

    // ---------------- reset during WAIT, stale done, then 65535 / 1
    a0 = 16'd40; b0 = 16'd6; req0 = 1'b1;
    step(3);                                   // ISSUE, WAIT 1, WAIT 2
    chk1("r_busy_wait", busy, 1'b1);
    rst = 1'b1; req0 = 1'b0;
    step(1);
    chk1("r_busy", busy, 1'b0);
    chk1("r_ack0", ack0, 1'b0);
    chk1("r_err", err_out, 1'b0);
    chk16("r_q", q_out, 16'd0);
    chk16("r_div_a", div_a, 16'd0);
    chk16("r_div_b", div_b, 16'd0);
    rst = 1'b0; div_done = 1'b1; div_q = 16'd6; div_r = 16'd4;
    step(1);
    chk1("r_stale_ack0", ack0, 1'b0);
    chk1("r_stale_busy", busy, 1'b0);
    chk16("r_stale_q", q_out, 16'd0);
    div_done = 1'b0;
    a0 = 16'hFFFF; b0 = 16'd1; req0 = 1'b1;
    step(1);                                   // ISSUE
    chk1("r_grant", grant_id, 1'b0);
    chk16("r_div_a_new", div_a, 16'hFFFF);
    step(1);
    div_done = 1'b1; div_q = 16'hFFFF; div_r = 16'd0;
    step(1);                                   // RESP
    chk1("r_ack0_new", ack0, 1'b1);
    chk16("r_q_new", q_out, 16'hFFFF);
    chk16("r_r_new", r_out, 16'd0);
    chk1("r_err_new", err_out, 1'b0);
    req0 = 1'b0; div_done = 1'b0;
    step(1);
    chk1("r_idle_end", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 64, maximum WAIT cycles before an abort (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports req0/req1, input, 1, requester k has an operation pending.
REQ-005 The block SHALL have ports a0/a1, input, 16, dividend of requester k, held stable while reqk=1.
REQ-006 The block SHALL have ports b0/b1, input, 16, divisor of requester k, held stable while reqk=1.
REQ-007 The block SHALL have ports ack0/ack1, output, 1, one-cycle result-valid pulse for requester k.
REQ-008 The block SHALL have ports q_out/r_out, output, 16, quotient and remainder of the current response.
REQ-009 The block SHALL have port err_out, output, 1, response error flag (divide-by-zero or timeout).
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 The block SHALL have port grant_id, output, 1, requester currently being served.
REQ-012 The block SHALL have port div_start, output, 1, one-cycle start pulse to the shared sequential divider.
REQ-013 The block SHALL have ports div_a/div_b, output, 16, operands to the divider, registered.
REQ-014 The block SHALL have port div_done, input, 1, divider completion (pulse or level).
REQ-015 The block SHALL have ports div_q/div_r, input, 16, divider quotient and remainder, valid while div_done=1.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT and RESP, one-hot or binary.
REQ-017 IDLE with any reqk=1 SHALL latch the winner's a/b into div_a/div_b, set grant_id, and go to ISSUE.
REQ-018 Arbitration SHALL be round-robin: a single requester wins; on simultaneous req0=req1=1, the requester not served last wins.
REQ-019 After reset, requester 0 SHALL win a tie.
REQ-020 When the winner's b=0 in IDLE, the block SHALL go directly to RESP with q_out=16'hFFFF, r_out=a, err_out=1, and no div_start.
REQ-021 ISSUE SHALL last exactly 1 cycle with div_start=1, then go to WAIT with the cycle counter cleared.
REQ-022 div_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-023 In WAIT, the first cycle with div_done=1 SHALL capture div_q/div_r into q_out/r_out, set err_out=0, and go to RESP.
REQ-024 In WAIT, if div_done stays 0 for TIMEOUT cycles, the block SHALL go to RESP with q_out=0, r_out=0, err_out=1.
REQ-025 RESP SHALL last exactly 1 cycle with ack[grant_id]=1 and the other ack=0, then go to IDLE.
REQ-026 The last-served pointer SHALL update in RESP.
REQ-027 q_out, r_out and err_out SHALL hold their values until the next RESP.
REQ-028 Requesters SHALL drop req on the edge ending RESP, so IDLE never re-issues a served operation.
REQ-029 Latency from req sample to ack SHALL be 1 + 1 + D + 1 cycles, where D is the divider's WAIT cycles; divide-by-zero latency SHALL be 2 cycles.
REQ-030 div_a/div_b SHALL remain stable from ISSUE through RESP.
REQ-031 The block SHALL hold at most one operation in flight, with no queueing.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE in any state and clear all outputs (ack0, ack1, div_start, busy, grant_id, err_out, q_out, r_out, div_a, div_b) to 0.
REQ-033 rst=1 SHALL reset the counter, and the pointer SHALL favour requester 0.
REQ-034 Reset mid-WAIT SHALL abort the operation without an ack; a late div_done after reset SHALL be ignored.

Verification
REQ-035 Scenario: req0 with a0=100, b0=7, divider D=17 -> div_start 1 cycle after the req sample; ack0 at 20 cycles; q_out=14, r_out=2, err_out=0.
REQ-036 Scenario: req0 and req1 raised in the same cycle after reset (a0=50/b0=5, a1=9/b1=4) -> req0 served first (q=10, r=0), then req1 (q=2, r=1); with both re-raised, req0 is served after req1.
REQ-037 Scenario: req1 with a1=1234, b1=0 -> ack1 2 cycles after the sample; q_out=FFFF, r_out=1234, err_out=1; div_start never asserts.
REQ-038 Scenario: divider model never asserts done, TIMEOUT=8 -> ack at WAIT cycle 8; q_out=0, r_out=0, err_out=1; busy falls the next cycle.
REQ-039 Scenario: rst pulsed during WAIT, then the stale div_done arrives -> no ack; busy=0 and all outputs 0; a subsequent req0 (a0=65535, b0=1) returns q=65535, r=0.
